// File: rtl/jogo_defs.sv
// Shared definitions for the move sequencer.
// Board size, FSM states and square index helper.
package jogo_defs;

  localparam int NUM_CASAS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEDE,
    S_ESPERA,
    S_CHECA,
    S_SCAN,
    S_VALIDA,
    S_FALHA
  } estado_t;

  function automatic logic [5:0] idx(
    input logic [2:0] c,
    input logic [2:0] l
  );
    return {c, l};
  endfunction

endpackage

// File: rtl/sequenciador_jogadas_varredor.sv
// Linear wrap-around scan for a free square.
// Tests one square per cycle; fim after 64 misses.
module varredor_casas
  import jogo_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  base,
  input  logic [63:0] tabuleiro,
  output logic        achou,
  output logic [5:0]  casa,
  output logic        fim
);

  logic       r_ativo;
  logic [5:0] r_ptr;
  logic [6:0] r_cnt;
  logic       w_todas;

  assign w_todas = (r_cnt == 7'(NUM_CASAS));
  assign casa    = r_ptr;
  assign achou   = r_ativo && !w_todas
                && !tabuleiro[r_ptr];
  assign fim     = r_ativo && w_todas;

  // Pointer and tested-square counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ativo <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_ativo <= 1'b1;
      r_ptr   <= base;
      r_cnt   <= '0;
    end else if (r_ativo) begin
      if (achou || fim) begin
        r_ativo <= 1'b0;
      end else begin
        r_ptr <= r_ptr + 6'd1;
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end

endmodule

// File: rtl/sequenciador_jogadas.sv
// Requests random squares until a free one shows up,
// then falls back to a linear scan of the board.
module sequenciador_jogadas
  import jogo_defs::*;
#(
  parameter int MAX_TENTATIVAS = 16,
  parameter int ESPERA         = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pedido,
  input  logic        ack,
  input  logic [63:0] tabuleiro,
  input  logic [2:0]  gen_coluna,
  input  logic [2:0]  gen_linha,
  output logic        novaJogada,
  output logic [2:0]  coluna,
  output logic [2:0]  linha,
  output logic        jogada_valida,
  output logic        falha,
  output logic        ocupado
);

  localparam int TW = $clog2(MAX_TENTATIVAS + 1);
  localparam int EW = (ESPERA > 1) ? $clog2(ESPERA) : 1;

  estado_t       r_estado, w_nxt;
  logic [EW-1:0] r_esp, w_esp;
  logic [TW-1:0] r_tent, w_tent;
  logic [5:0]    r_coord, w_coord;
  logic [5:0]    w_idx, w_base, w_casa;
  logic          w_start, w_achou, w_fim;

  assign w_idx  = idx(gen_coluna, gen_linha);
  assign w_base = w_idx + 6'd1;

  varredor_casas u_varredor (
    .clock     (clock),
    .reset     (reset),
    .start     (w_start),
    .base      (w_base),
    .tabuleiro (tabuleiro),
    .achou     (w_achou),
    .casa      (w_casa),
    .fim       (w_fim)
  );

  // State, counters and chosen square
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= S_IDLE;
      r_esp    <= '0;
      r_tent   <= '0;
      r_coord  <= '0;
    end else begin
      r_estado <= w_nxt;
      r_esp    <= w_esp;
      r_tent   <= w_tent;
      r_coord  <= w_coord;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    w_nxt         = r_estado;
    w_esp         = r_esp;
    w_tent        = r_tent;
    w_coord       = r_coord;
    w_start       = 1'b0;
    novaJogada    = 1'b0;
    jogada_valida = 1'b0;
    falha         = 1'b0;
    ocupado       = 1'b1;
    coluna        = 3'd0;
    linha         = 3'd0;
    unique case (r_estado)
      S_IDLE: begin
        ocupado = 1'b0;
        if (pedido) begin
          w_nxt  = S_PEDE;
          w_tent = '0;
        end
      end
      S_PEDE: begin
        novaJogada = 1'b1;
        w_nxt      = S_ESPERA;
        w_esp      = '0;
      end
      S_ESPERA: begin
        if (r_esp == EW'(ESPERA - 1))
          w_nxt = S_CHECA;
        else
          w_esp = r_esp + EW'(1);
      end
      S_CHECA: begin
        if (!tabuleiro[w_idx]) begin
          w_coord = w_idx;
          w_nxt   = S_VALIDA;
        end else begin
          w_tent = r_tent + TW'(1);
          if (w_tent == TW'(MAX_TENTATIVAS)) begin
            w_start = 1'b1;
            w_nxt   = S_SCAN;
          end else begin
            w_nxt = S_PEDE;
          end
        end
      end
      S_SCAN: begin
        if (w_achou) begin
          w_coord = w_casa;
          w_nxt   = S_VALIDA;
        end else if (w_fim) begin
          w_nxt = S_FALHA;
        end
      end
      S_VALIDA: begin
        jogada_valida = 1'b1;
        coluna        = r_coord[5:3];
        linha         = r_coord[2:0];
        if (ack) w_nxt = S_IDLE;
      end
      S_FALHA: begin
        falha = 1'b1;
        if (ack) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequenciador_jogadas.sv
// Bench for sequenciador_jogadas: timeline model,
// per-cycle compare, directed and random requests.
module tb_sequenciador_jogadas;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pedido = 1'b0;
  logic        ack = 1'b0;
  logic [63:0] tab = '0;
  logic [5:0]  gen = '0;
  logic        novaJogada, jogada_valida;
  logic        falha, ocupado;
  logic [2:0]  coluna, linha;

  sequenciador_jogadas dut (
    .clock         (clock),
    .reset         (reset),
    .pedido        (pedido),
    .ack           (ack),
    .tabuleiro     (tab),
    .gen_coluna    (gen[5:3]),
    .gen_linha     (gen[2:0]),
    .novaJogada    (novaJogada),
    .coluna        (coluna),
    .linha         (linha),
    .jogada_valida (jogada_valida),
    .falha         (falha),
    .ocupado       (ocupado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  // generator: draw list, latched on novaJogada
  logic [5:0] draws [16];
  int   gi = 0;
  int   npulse = 0;
  bit   pend = 0;
  logic [5:0] nxt = '0;

  always @(negedge clock) begin
    if (!ocupado) begin
      gi = 0;
      npulse = 0;
    end
    pend = 0;
    if (novaJogada) begin
      nxt = draws[gi % 16];
      gi++;
      npulse++;
      pend = 1;
    end
  end

  always @(posedge clock)
    if (pend) gen <= nxt;

  // model: per request, result time and value
  int   m_mode = 0;
  int   m_n = 0;
  int   m_R = 0;
  int   m_nd = 0;
  bit   m_fail = 0;
  logic [5:0] m_sq = '0;

  task automatic plan();
    int base;
    int sq;
    m_fail = 0;
    for (int i = 0; i < 16; i++) begin
      if (!tab[draws[i]]) begin
        m_nd = i + 1;
        m_R  = 4 * (i + 1);
        m_sq = draws[i];
        return;
      end
    end
    m_nd = 16;
    base = (int'(draws[15]) + 1) % 64;
    for (int j = 0; j < 64; j++) begin
      sq = (base + j) % 64;
      if (!tab[sq]) begin
        m_R  = 65 + j;
        m_sq = 6'(sq);
        return;
      end
    end
    m_R = 129;
    m_fail = 1;
  endtask

  always @(posedge clock) begin
    if (!reset) m_mode = 0;
    else case (m_mode)
      0: if (pedido) begin
        plan();
        m_mode = 1;
        m_n = 0;
      end
      1: begin
        m_n++;
        if (m_n == m_R) m_mode = 2;
      end
      default: if (ack) m_mode = 0;
    endcase
  end

  // compare every cycle
  always begin
    logic [9:0] e;
    logic ev;
    @(posedge clock);
    #1;
    ev = (m_mode == 2) && !m_fail;
    e = {m_mode != 0,
         m_mode == 1 && m_n % 4 == 0
           && m_n / 4 < m_nd,
         ev,
         m_mode == 2 && m_fail,
         ev ? m_sq : 6'd0};
    chk("cycle",
        {ocupado, novaJogada, jogada_valida,
         falha, coluna, linha}, 32'(e));
  end

  function automatic logic [9:0] outs();
    return {ocupado, novaJogada, jogada_valida,
            falha, coluna, linha};
  endfunction

  task automatic request(output int lat);
    bit ok = 0;
    @(negedge clock);
    pedido = 1;
    @(posedge clock);
    @(negedge clock);
    pedido = 0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      if (jogada_valida || falha) begin
        ok = 1;
        break;
      end
      @(negedge clock);
      lat++;
    end
    chk("no_result_timeout", 32'(ok), 1);
  endtask

  task automatic do_ack();
    @(negedge clock);
    ack = 1;
    @(negedge clock);
    ack = 0;
    chk("ack_idle", 32'(outs()), 0);
  endtask

  task automatic rand_draws();
    for (int i = 0; i < 16; i++)
      draws[i] = 6'($urandom_range(0, 62));
  endtask

  int lat;
  int p0;

  initial begin
    rand_draws();
    repeat (2) @(negedge clock);
    chk("reset_outs", 32'(outs()), 0);
    reset = 1;

    // 1: empty board, first draw taken
    tab = '0;
    draws[0] = 6'd21;
    request(lat);
    chk("t1_lat", lat, 4);
    chk("t1_pulses", npulse, 1);
    chk("t1_coord", {coluna, linha}, 6'o25);
    do_ack();

    // 2: two occupied draws, then 33
    tab = '0;
    tab[10] = 1;
    tab[20] = 1;
    draws[0] = 6'd10;
    draws[1] = 6'd20;
    draws[2] = 6'd33;
    request(lat);
    chk("t2_lat", lat, 12);
    chk("t2_pulses", npulse, 3);
    chk("t2_coord", {coluna, linha}, 6'o41);
    do_ack();

    // 3: only square 63 free, found by scan
    tab = ~(64'd1 << 63);
    rand_draws();
    draws[15] = 6'd40;
    request(lat);
    chk("t3_lat", lat, 87);
    chk("t3_pulses", npulse, 16);
    chk("t3_coord", {coluna, linha}, 6'o77);
    do_ack();

    // 4: full board
    tab = '1;
    rand_draws();
    request(lat);
    chk("t4_lat", lat, 129);
    chk("t4_pulses", npulse, 16);
    chk("t4_falha", {falha, jogada_valida}, 2'b10);
    do_ack();

    // 5: reset in ESPERA and in VALIDA
    tab = '0;
    draws[0] = 6'd9;
    @(negedge clock);
    pedido = 1;
    @(posedge clock);
    @(negedge clock);
    pedido = 0;
    @(negedge clock);
    reset = 0;
    #1 chk("t5_rst_espera", 32'(outs()), 0);
    repeat (2) @(negedge clock);
    reset = 1;
    request(lat);
    chk("t5_lat", lat, 4);
    chk("t5_coord", {coluna, linha}, 6'o11);
    @(negedge clock);
    reset = 0;
    #1 chk("t5_rst_valida", 32'(outs()), 0);
    repeat (2) @(negedge clock);
    reset = 1;
    request(lat);
    chk("t5_lat2", lat, 4);
    do_ack();

    // 6: hold VALIDA, toggle pedido
    draws[0] = 6'd50;
    request(lat);
    p0 = npulse;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      pedido = ~pedido;
      chk("t6_hold",
          {jogada_valida, coluna, linha},
          {1'b1, 6'o62});
    end
    pedido = 0;
    chk("t6_pulses", npulse, p0);
    do_ack();

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      if (!ocupado && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: tab = '0;
          1: tab = '1;
          2: tab = {$urandom, $urandom}
                 & {$urandom, $urandom};
          3: tab = ~(64'd1 << $urandom_range(0, 63));
          default: tab = {$urandom, $urandom};
        endcase
        rand_draws();
      end
      pedido = ($urandom_range(0, 2) == 0);
      ack    = ($urandom_range(0, 3) == 0);
    end
    pedido = 0;
    ack = 0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
